// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two requester FIFOs (A = ALU path, B = multi-cycle/load path)
// are round-robin arbitrated onto the single register-file write port. A registered
// write stage drives rd/busW/writeEnable. Hazard outputs flag source registers that
// still have a write pending in either FIFO or in the write stage.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_rd,
    input  logic [31:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_rd,
    input  logic [31:0]      b_data,
    output logic [4:0]       rd,
    output logic [31:0]      busW,
    output logic             writeEnable,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    output logic             hazard_a,
    output logic             hazard_b,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count,
    output logic             idle
);

    localparam int PTR_W = $clog2(DEPTH);

    // Which requester won the most recent contended arbitration.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    // Requester inputs gathered into index-0 = A, index-1 = B form.
    logic [1:0]             req_valid;
    logic [1:0][4:0]        req_rd;
    logic [1:0][31:0]       req_data;

    // Per-FIFO status exported out of the generate loop.
    logic [1:0]             full_vec;
    logic [1:0]             nonempty_vec;
    logic [1:0]             ready_vec;
    logic [1:0]             match_rs_vec;
    logic [1:0]             match_rt_vec;
    logic [1:0][4:0]        head_rd_vec;
    logic [1:0][31:0]       head_data_vec;
    logic [1:0][CNT_W-1:0]  count_vec;

    // Arbiter decision for this cycle (one-hot, or zero when both FIFOs are empty).
    logic [1:0]             grant;
    grant_t                 last_grant_reg;
    grant_t                 last_grant_next;

    // Registered write stage.
    logic [4:0]             rd_reg;
    logic [31:0]            busw_reg;
    logic                   we_reg;
    logic [4:0]             sel_rd;
    logic [31:0]            sel_data;

    assign req_valid = {b_valid, a_valid};
    assign req_rd    = {b_rd, a_rd};
    assign req_data  = {b_data, a_data};

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [4:0]       rd_mem   [DEPTH];
        logic [31:0]      data_mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr_reg;
        logic [PTR_W-1:0] rd_ptr_reg;
        logic [CNT_W-1:0] count_reg;
        logic [DEPTH-1:0] occupied;
        logic [DEPTH-1:0] slot_rs;
        logic [DEPTH-1:0] slot_rt;
        logic             push;
        logic             pop;

        assign full_vec[gi]     = (count_reg == CNT_W'(DEPTH));
        assign nonempty_vec[gi] = (count_reg != '0);
        // Ready depends only on registered occupancy; held low while in reset.
        assign ready_vec[gi]    = reset && !full_vec[gi];
        // A push while full is dropped even if the same edge pops.
        assign push             = req_valid[gi] && ready_vec[gi];
        assign pop              = grant[gi];
        assign head_rd_vec[gi]   = rd_mem[rd_ptr_reg];
        assign head_data_vec[gi] = data_mem[rd_ptr_reg];
        assign count_vec[gi]     = count_reg;

        // Entry storage: written on push, never reset (occupancy comes from the pointers).
        always_ff @(posedge clk) begin
            if (push) begin
                rd_mem[wr_ptr_reg]   <= req_rd[gi];
                data_mem[wr_ptr_reg] <= req_data[gi];
            end
        end

        // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end

        // A slot is live when its distance from the read pointer is below the count.
        for (genvar si = 0; si < DEPTH; si++) begin : g_slot
            logic [PTR_W-1:0] offset;
            assign offset       = PTR_W'(si) - rd_ptr_reg;
            assign occupied[si] = (CNT_W'(offset) < count_reg);
            assign slot_rs[si]  = occupied[si] && (rd_mem[si] == rs);
            assign slot_rt[si]  = occupied[si] && (rd_mem[si] == rt);
        end

        assign match_rs_vec[gi] = |slot_rs;
        assign match_rt_vec[gi] = |slot_rt;
    end

    // Round-robin arbitration; last_grant only moves when both FIFOs compete.
    always_comb begin
        grant           = 2'b00;
        last_grant_next = last_grant_reg;
        if (nonempty_vec[0] && nonempty_vec[1]) begin
            if (last_grant_reg == GRANT_B) begin
                grant           = 2'b01;
                last_grant_next = GRANT_A;
            end else begin
                grant           = 2'b10;
                last_grant_next = GRANT_B;
            end
        end else if (nonempty_vec[0]) begin
            grant = 2'b01;
        end else if (nonempty_vec[1]) begin
            grant = 2'b10;
        end
    end

    // Head of the granted FIFO feeds the write stage.
    always_comb begin
        sel_rd   = head_rd_vec[0];
        sel_data = head_data_vec[0];
        if (grant[1]) begin
            sel_rd   = head_rd_vec[1];
            sel_data = head_data_vec[1];
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= GRANT_B;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

    // Write stage: r0 entries are consumed but never strobe the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_reg   <= '0;
            busw_reg <= '0;
            we_reg   <= 1'b0;
        end else if (grant != 2'b00) begin
            rd_reg   <= sel_rd;
            busw_reg <= sel_data;
            we_reg   <= (sel_rd != 5'd0);
        end else begin
            we_reg   <= 1'b0;
        end
    end

    assign a_ready     = ready_vec[0];
    assign b_ready     = ready_vec[1];
    assign a_count     = count_vec[0];
    assign b_count     = count_vec[1];
    assign rd          = rd_reg;
    assign busW        = busw_reg;
    assign writeEnable = we_reg;

    // Hazards look only at stored state; r0 never conflicts.
    assign hazard_a = (rs != 5'd0) &&
                      ((|match_rs_vec) || (we_reg && (rd_reg == rs)));
    assign hazard_b = (rt != 5'd0) &&
                      ((|match_rt_vec) || (we_reg && (rd_reg == rt)));

    assign idle = !nonempty_vec[0] && !nonempty_vec[1] && !we_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed cases plus randomized traffic checked
// every cycle against a queue-based model of the writeback arbiter.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             a_valid, b_valid;
    logic             a_ready, b_ready;
    logic [4:0]       a_rd, b_rd;
    logic [31:0]      a_data, b_data;
    logic [4:0]       rd;
    logic [31:0]      busW;
    logic             writeEnable;
    logic [4:0]       rs, rt;
    logic             hazard_a, hazard_b;
    logic [CNT_W-1:0] a_count, b_count;
    logic             idle;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rd(rd), .busW(busW), .writeEnable(writeEnable),
        .rs(rs), .rt(rt), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .a_count(a_count), .b_count(b_count), .idle(idle)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    // Reference model state.
    entry_t      qa[$];
    entry_t      qb[$];
    bit          last_was_b;
    logic [4:0]  m_rd;
    logic [31:0] m_busw;
    logic        m_we;

    logic [4:0]  wr_log[$];
    int checks   = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_we && m_rd == r) return 1'b1;
        foreach (qa[i]) if (qa[i].rd == r) return 1'b1;
        foreach (qb[i]) if (qb[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_was_b = 1'b1;
        m_rd   = '0;
        m_busw = '0;
        m_we   = 1'b0;
    endtask

    // One clock edge of the reference: pop per round-robin rules, then accept pushes.
    task automatic model_edge();
        bit     room_a, room_b, have_a, have_b;
        int     g;
        entry_t h;
        room_a = (qa.size() < DEPTH);
        room_b = (qb.size() < DEPTH);
        have_a = (qa.size() > 0);
        have_b = (qb.size() > 0);
        g = 0;
        if (have_a && have_b) begin
            g = last_was_b ? 1 : 2;
            last_was_b = (g == 2);
        end else if (have_a) begin
            g = 1;
        end else if (have_b) begin
            g = 2;
        end
        if (g == 1) h = qa.pop_front();
        if (g == 2) h = qb.pop_front();
        if (g != 0) begin
            m_rd   = h.rd;
            m_busw = h.data;
            m_we   = (h.rd != 5'd0);
        end else begin
            m_we = 1'b0;
        end
        if (a_valid && room_a) qa.push_back({a_rd, a_data});
        if (b_valid && room_b) qb.push_back({b_rd, b_data});
    endtask

    task automatic check_outputs();
        check_value("a_ready", a_ready, reset && (qa.size() < DEPTH));
        check_value("b_ready", b_ready, reset && (qb.size() < DEPTH));
        check_value("a_count", a_count, qa.size());
        check_value("b_count", b_count, qb.size());
        check_value("writeEnable", writeEnable, m_we);
        check_value("rd", rd, m_rd);
        check_value("busW", busW, m_busw);
        check_value("hazard_a", hazard_a, pending(rs));
        check_value("hazard_b", hazard_b, pending(rt));
        check_value("idle", idle, (qa.size() == 0) && (qb.size() == 0) && !m_we);
    endtask

    task automatic cycle(input logic va, input logic [4:0] ard, input logic [31:0] adat,
                         input logic vb, input logic [4:0] brd, input logic [31:0] bdat);
        @(negedge clk);
        a_valid = va; a_rd = ard; a_data = adat;
        b_valid = vb; b_rd = brd; b_data = bdat;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (writeEnable) begin
            wr_log.push_back(rd);
            $display("write rd=%0d busW=%08h a_count=%0d b_count=%0d", rd, busW, a_count, b_count);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic [4:0] exp_seq2 [8];
        int pct;
        exp_seq2 = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};

        reset = 1'b0;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        rs = 0; rt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        // Single write with hazard tracking on rs=5.
        rs = 5'd5; rt = 5'd0;
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check_value("case1_hazard_pending", hazard_a, 1'b1);
        idle_cycles(1);
        check_value("case1_we", writeEnable, 1'b1);
        idle_cycles(1);
        check_value("case1_we_drop", writeEnable, 1'b0);
        check_value("case1_hazard_clear", hazard_a, 1'b0);

        // Contention: interleaved grant order.
        wr_log.delete();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'(i + 1), 32'(i), 1'b1, 5'(i + 9), 32'(i + 100));
        idle_cycles(6);
        check_value("case2_len", wr_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < wr_log.size()) check_value($sformatf("case2_rd%0d", i), wr_log[i], exp_seq2[i]);

        // Full: both push every cycle until A saturates.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 5'(i + 1), 32'(i * 7), 1'b1, 5'(i + 16), 32'(i * 11));
        check_value("case3_a_full", a_count, DEPTH);
        idle_cycles(10);

        // r0 entry is drained silently.
        rs = 5'd0;
        cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        check_value("case4_count", a_count, 1);
        idle_cycles(3);
        check_value("case4_we", writeEnable, 1'b0);

        // Reset mid-stream.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'(i + 1), 32'(i), 1'b1, 5'(i + 4), 32'(i));
        rs = 5'd4; rt = 5'd3;
        @(negedge clk);
        a_valid = 0; b_valid = 0;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        rs = 5'd7;
        cycle(1'b1, 5'd7, 32'hCAFE0001, 1'b0, 5'd0, 32'd0);
        idle_cycles(1);
        check_value("case5_we", writeEnable, 1'b1);
        check_value("case5_busW", busW, 32'hCAFE0001);
        idle_cycles(1);

        // Pointer wrap on B.
        wr_log.delete();
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i * 3));
            idle_cycles(1);
        end
        idle_cycles(3);
        check_value("case6_len", wr_log.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < wr_log.size()) check_value($sformatf("case6_rd%0d", i), wr_log[i], 5'(i + 1));

        // Randomized traffic, alternating fill-heavy and drain-heavy phases.
        for (int i = 0; i < 600; i++) begin
            pct = ((i / 50) % 2 == 1) ? 85 : 30;
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            cycle($urandom_range(0, 99) < pct, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < pct, 5'($urandom_range(0, 7)), $urandom);
        end
        idle_cycles(12);
        check_value("final_idle", idle, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
